// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX serializer between NUM_CH
// byte-stream requesters. It presents a FIFO-style interface (data /
// available / rd) to the serializer. It also drives the frame config of the
// winning channel. Data and config are latched when a byte is granted and do
// not change again until the next grant, so a frame never sees mixed settings.
module uart_tx_sched #(
  parameter int NUM_CH              = 4,
  parameter int DATA_WIDTH          = 8,
  parameter int DATA_WIDTH_OPTION_W = 2,
  parameter int PARITY_OPTION_W     = 2,
  parameter int STOP_BIT_OPTION_W   = 1,
  parameter int BURST_LEN           = 1,
  parameter int CFG_W               = DATA_WIDTH_OPTION_W + PARITY_OPTION_W + STOP_BIT_OPTION_W,
  parameter int CH_W                = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sched_en,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
  input  logic [NUM_CH*CFG_W-1:0]        ch_cfg,
  output logic [NUM_CH-1:0]              ch_ready,
  output logic [DATA_WIDTH-1:0]          data_in_tx,
  output logic                           fifo_available,
  input  logic                           fifo_rd,
  input  logic                           transaction_en,
  output logic [DATA_WIDTH_OPTION_W-1:0] data_width_option,
  output logic [PARITY_OPTION_W-1:0]     parity_option,
  output logic [STOP_BIT_OPTION_W-1:0]   stop_bit_option,
  output logic [CH_W-1:0]                grant_id,
  output logic                           busy
);

  // Wide enough for BURST_LEN up to 15.
  localparam int BC_W = 4;

  typedef enum logic [1:0] {IDLE, ARB, OFFER, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        grant_q, grant_d;
  logic [BC_W-1:0]        burst_q, burst_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CFG_W-1:0]       cfg_q, cfg_d;
  logic [CH_W-1:0]        win, cand;
  logic                   keep, found;

  // Winner selection. The last owner is kept while its burst has room.
  // burst_q == 0 means no frame has been granted since reset, so there is no
  // owner to keep and the search starts at channel 0.
  always_comb begin
    keep  = (burst_q != '0) && (burst_q < BC_W'(BURST_LEN)) && ch_valid[grant_q];
    win   = grant_q;
    found = keep;
    cand  = '0;
    if (!keep) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = CH_W'((int'(grant_q) + k) % NUM_CH);
        if (!found && ch_valid[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Next-state and handshake logic. Holding registers load only on ARB->OFFER.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    data_d   = data_q;
    cfg_d    = cfg_q;
    ch_ready = '0;
    case (state_q)
      IDLE:  if (sched_en && !transaction_en) state_d = ARB;
      ARB: begin
        if (!sched_en) begin
          state_d = IDLE;
        end else if (found) begin
          ch_ready[win] = 1'b1;
          grant_d       = win;
          burst_d       = keep ? burst_q + 1'b1 : BC_W'(1);
          data_d        = ch_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          cfg_d         = ch_cfg[int'(win)*CFG_W +: CFG_W];
          state_d       = OFFER;
        end
      end
      OFFER: if (fifo_rd) state_d = BUSY;
      BUSY:  if (!transaction_en) state_d = sched_en ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers; reset drops any byte not yet consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= CH_W'(NUM_CH - 1);
      burst_q <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
    end
  end

  assign fifo_available    = (state_q == OFFER);
  assign busy              = (state_q != IDLE);
  assign grant_id          = grant_q;
  assign data_in_tx        = data_q;
  assign stop_bit_option   = cfg_q[STOP_BIT_OPTION_W-1:0];
  assign parity_option     = cfg_q[STOP_BIT_OPTION_W +: PARITY_OPTION_W];
  assign data_width_option = cfg_q[STOP_BIT_OPTION_W+PARITY_OPTION_W +: DATA_WIDTH_OPTION_W];

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched. Two instances share all inputs: a uses
// BURST_LEN=1 and b uses BURST_LEN=3. Frame timing does not depend on which
// channel wins, so both stay in lockstep and are checked together.
module tb_uart_tx_sched;
  localparam int NUM_CH = 4;
  localparam int CD_W   = 32;
  localparam int CC_W   = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              sched_en = 1'b0;
  logic [3:0]        ch_valid = '0;
  logic [CD_W-1:0]   ch_data = '0;
  logic [CC_W-1:0]   ch_cfg = '0;
  logic              fifo_rd = 1'b0;
  logic              transaction_en = 1'b0;

  logic [3:0] rdy_a, rdy_b;
  logic [7:0] dtx_a, dtx_b;
  logic       fav_a, fav_b, busy_a, busy_b;
  logic [1:0] dwo_a, dwo_b, par_a, par_b, gid_a, gid_b;
  logic       stp_a, stp_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_CH(4), .BURST_LEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_cfg(ch_cfg), .ch_ready(rdy_a), .data_in_tx(dtx_a),
    .fifo_available(fav_a), .fifo_rd(fifo_rd), .transaction_en(transaction_en),
    .data_width_option(dwo_a), .parity_option(par_a), .stop_bit_option(stp_a),
    .grant_id(gid_a), .busy(busy_a));

  uart_tx_sched #(.NUM_CH(4), .BURST_LEN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_cfg(ch_cfg), .ch_ready(rdy_b), .data_in_tx(dtx_b),
    .fifo_available(fav_b), .fifo_rd(fifo_rd), .transaction_en(transaction_en),
    .data_width_option(dwo_b), .parity_option(par_b), .stop_bit_option(stp_b),
    .grant_id(gid_b), .busy(busy_b));

  typedef struct packed {
    logic       timeout;
    logic [3:0] rdy_a, rdy_b, fav_a, fav_b;
    logic [1:0] gid_a, gid_b;
    logic [7:0] data_a, data_b;
    logic [4:0] cfg_a, cfg_b;
    logic       held_a, held_b;
    logic [7:0] wait_cyc;
    logic [CD_W-1:0] snap_d;
    logic [CC_W-1:0] snap_c;
  } frame_t;

  // Reference: keep the owner while it is valid and its run is shorter than
  // the burst length (no owner right after reset), else first valid channel
  // after the last owner, wrapping around.
  function automatic bit model_keep(input logic [3:0] v, input int last, input int cnt, input int blen);
    int unsigned vi;
    vi = {28'b0, v};
    return (cnt > 0) && (cnt < blen) && (((vi >> last) & 1) == 1);
  endfunction

  function automatic int model_pick(input logic [3:0] v, input int last, input int cnt, input int blen);
    int unsigned vi;
    int idx;
    vi = {28'b0, v};
    if (model_keep(v, last, cnt, blen)) return last;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (last + k) % NUM_CH;
      if (((vi >> idx) & 1) == 1) return idx;
    end
    return 0;
  endfunction

  // Expected frame observation: one-hot accept, offer high in cycles 1-2,
  // winner's byte/config on the outputs, held through the whole frame.
  function automatic logic [48:0] exp_vec(input int ea, input int eb,
                                          input logic [CD_W-1:0] d, input logic [CC_W-1:0] c);
    logic [3:0] oa, ob;
    oa = 4'd1 << ea;
    ob = 4'd1 << eb;
    return {1'b0, oa, ob, 4'b0110, 4'b0110, 2'(ea), 2'(eb),
            d[ea*8 +: 8], d[eb*8 +: 8], c[ea*5 +: 5], c[eb*5 +: 5], 2'b11};
  endfunction

  function automatic logic [48:0] obs_vec(input frame_t o);
    return {o.timeout, o.rdy_a, o.rdy_b, o.fav_a, o.fav_b, o.gid_a, o.gid_b,
            o.data_a, o.data_b, o.cfg_a, o.cfg_b, o.held_a, o.held_b};
  endfunction

  function automatic bit hold_a(input frame_t o);
    return dtx_a === o.data_a && {dwo_a, par_a, stp_a} === o.cfg_a &&
           gid_a === o.gid_a && rdy_a === 4'b0 && busy_a === 1'b1;
  endfunction

  function automatic bit hold_b(input frame_t o);
    return dtx_b === o.data_b && {dwo_b, par_b, stp_b} === o.cfg_b &&
           gid_b === o.gid_b && rdy_b === 4'b0 && busy_b === 1'b1;
  endfunction

  task automatic apply_reset();
    fifo_rd = 1'b0;
    transaction_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Serializer model for one frame: waits for the accept, pulses fifo_rd
  // one cycle after the offer appears (after 'stall' extra OFFER cycles with
  // transaction_en already high), then holds transaction_en for 4 cycles.
  // Channel inputs are scrambled during the frame to prove outputs are held.
  task automatic drive_frame(input int stall, input bit drop_en, output frame_t o);
    logic [CD_W-1:0] sd;
    logic [CC_W-1:0] sc;
    int n;
    o = '0;
    o.held_a = 1'b1;
    o.held_b = 1'b1;
    n = 0;
    #1;
    while ((rdy_a | rdy_b) == 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    o.wait_cyc = 8'(n);
    if ((rdy_a | rdy_b) == 4'b0) begin
      o.timeout = 1'b1;
      return;
    end
    o.rdy_a = rdy_a; o.rdy_b = rdy_b;
    o.fav_a[0] = fav_a; o.fav_b[0] = fav_b;
    o.snap_d = ch_data; o.snap_c = ch_cfg;
    @(negedge clk);
    o.fav_a[1] = fav_a; o.fav_b[1] = fav_b;
    o.gid_a = gid_a; o.gid_b = gid_b;
    o.data_a = dtx_a; o.data_b = dtx_b;
    o.cfg_a = {dwo_a, par_a, stp_a}; o.cfg_b = {dwo_b, par_b, stp_b};
    sd = ch_data; sc = ch_cfg;
    ch_data = CD_W'($urandom);
    ch_cfg = CC_W'($urandom);
    transaction_en = (stall > 0);
    repeat (stall + 1) begin
      @(negedge clk);
      o.fav_a[2] = fav_a; o.fav_b[2] = fav_b;
      o.held_a &= hold_a(o) && fav_a === 1'b1;
      o.held_b &= hold_b(o) && fav_b === 1'b1;
    end
    fifo_rd = 1'b1;
    transaction_en = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    o.fav_a[3] = fav_a; o.fav_b[3] = fav_b;
    if (drop_en) sched_en = 1'b0;
    repeat (4) begin
      o.held_a &= hold_a(o) && fav_a === 1'b0;
      o.held_b &= hold_b(o) && fav_b === 1'b0;
      @(negedge clk);
    end
    ch_data = sd;
    ch_cfg = sc;
    transaction_en = 1'b0;
  endtask

  task automatic test_reset();
    sched_en = 1'b0;
    ch_valid = 4'hF;
    ch_data = CD_W'($urandom);
    ch_cfg = CC_W'($urandom);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_a, fav_a, dtx_a, dwo_a, par_a, stp_a, gid_a, busy_a,
         rdy_b, fav_b, dtx_b, dwo_b, par_b, stp_b, gid_b, busy_b} !==
        {4'b0, 1'b0, 8'h00, 2'b0, 2'b0, 1'b0, 2'd3, 1'b0,
         4'b0, 1'b0, 8'h00, 2'b0, 2'b0, 1'b0, 2'd3, 1'b0}) begin
      fails++;
      $display("FAIL reset_values a: rdy=%b av=%b d=%h gid=%0d busy=%b b: rdy=%b av=%b gid=%0d busy=%b expected zeros, gid=3",
               rdy_a, fav_a, dtx_a, gid_a, busy_a, rdy_b, fav_b, gid_b, busy_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, fav_a, rdy_a, busy_b, fav_b, rdy_b} !== 12'b0) begin
      fails++;
      $display("FAIL idle_hold busy=%b/%b av=%b/%b rdy=%b/%b expected all 0",
               busy_a, busy_b, fav_a, fav_b, rdy_a, rdy_b);
    end
  endtask

  task automatic test_single();
    frame_t o;
    sched_en = 1'b1;
    ch_valid = 4'b0001;
    ch_data = {24'($urandom), 8'hA5};
    ch_cfg = {15'($urandom), 5'b11000};
    apply_reset();
    drive_frame(0, 1'b0, o);
    checks++;
    if (obs_vec(o) !== exp_vec(0, 0, o.snap_d, o.snap_c)) begin
      fails++;
      $display("FAIL single_frame got=%h expected=%h", obs_vec(o), exp_vec(0, 0, o.snap_d, o.snap_c));
    end
    checks++;
    if ({o.data_a, o.cfg_a, o.wait_cyc} !== {8'hA5, 5'b11000, 8'd1}) begin
      fails++;
      $display("FAIL single_values data=%h cfg=%b wait=%0d expected a5 11000 1", o.data_a, o.cfg_a, o.wait_cyc);
    end
    ch_data[7:0] = 8'h3C;
    drive_frame(0, 1'b0, o);
    checks++;
    if (obs_vec(o) !== exp_vec(0, 0, o.snap_d, o.snap_c) || o.wait_cyc !== 8'd1 || o.data_a !== 8'h3C) begin
      fails++;
      $display("FAIL back_to_back got=%h wait=%0d expected=%h wait=1", obs_vec(o), o.wait_cyc,
               exp_vec(0, 0, o.snap_d, o.snap_c));
    end
  endtask

  task automatic test_round_robin();
    frame_t o;
    int ea[6] = '{0, 1, 2, 3, 0, 1};
    int eb[6] = '{0, 0, 0, 1, 1, 1};
    sched_en = 1'b1;
    ch_valid = 4'hF;
    ch_data = CD_W'($urandom);
    ch_cfg = CC_W'($urandom);
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      drive_frame(0, 1'b0, o);
      checks++;
      if (obs_vec(o) !== exp_vec(ea[f], eb[f], o.snap_d, o.snap_c)) begin
        fails++;
        $display("FAIL round_robin frame %0d got=%h expected=%h", f, obs_vec(o),
                 exp_vec(ea[f], eb[f], o.snap_d, o.snap_c));
      end
      ch_data = CD_W'($urandom);
    end
  endtask

  task automatic test_burst();
    frame_t o;
    int ea[7] = '{1, 2, 1, 2, 1, 2, 1};
    int eb[7] = '{1, 1, 1, 2, 2, 2, 1};
    sched_en = 1'b1;
    ch_valid = 4'b0001;
    ch_data = CD_W'($urandom);
    ch_cfg = CC_W'($urandom);
    apply_reset();
    drive_frame(0, 1'b0, o);
    checks++;
    if (obs_vec(o) !== exp_vec(0, 0, o.snap_d, o.snap_c)) begin
      fails++;
      $display("FAIL burst_setup got=%h expected=%h", obs_vec(o), exp_vec(0, 0, o.snap_d, o.snap_c));
    end
    ch_valid = 4'b0110;
    for (int f = 0; f < 7; f++) begin
      drive_frame(0, 1'b0, o);
      checks++;
      if (obs_vec(o) !== exp_vec(ea[f], eb[f], o.snap_d, o.snap_c)) begin
        fails++;
        $display("FAIL burst frame %0d got=%h expected=%h", f, obs_vec(o),
                 exp_vec(ea[f], eb[f], o.snap_d, o.snap_c));
      end
      ch_data = CD_W'($urandom);
    end
  endtask

  task automatic test_cfg_isolation();
    frame_t o;
    int ea[4] = '{0, 1, 0, 1};
    int eb[4] = '{0, 0, 0, 1};
    logic [4:0] cfg_of[2] = '{5'b00101, 5'b11110};
    sched_en = 1'b1;
    ch_valid = 4'b0011;
    ch_data = CD_W'($urandom);
    ch_cfg = {10'($urandom), 5'b11110, 5'b00101};
    apply_reset();
    for (int f = 0; f < 4; f++) begin
      // Odd frames raise transaction_en during OFFER before fifo_rd.
      drive_frame((f % 2) * 2, 1'b0, o);
      checks++;
      if (obs_vec(o) !== exp_vec(ea[f], eb[f], o.snap_d, o.snap_c) ||
          o.cfg_a !== cfg_of[ea[f]] || o.cfg_b !== cfg_of[eb[f]]) begin
        fails++;
        $display("FAIL cfg_isolation frame %0d got=%h cfg=%b/%b expected=%h cfg=%b/%b", f, obs_vec(o),
                 o.cfg_a, o.cfg_b, exp_vec(ea[f], eb[f], o.snap_d, o.snap_c), cfg_of[ea[f]], cfg_of[eb[f]]);
      end
      ch_data = CD_W'($urandom);
    end
  endtask

  task automatic test_sched_en_drop();
    frame_t o;
    bit ok;
    sched_en = 1'b1;
    ch_valid = 4'b0100;
    ch_data = CD_W'($urandom);
    ch_cfg = CC_W'($urandom);
    apply_reset();
    drive_frame(0, 1'b1, o);
    checks++;
    if (obs_vec(o) !== exp_vec(2, 2, o.snap_d, o.snap_c)) begin
      fails++;
      $display("FAIL drop_frame got=%h expected=%h", obs_vec(o), exp_vec(2, 2, o.snap_d, o.snap_c));
    end
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      ok &= {busy_a, busy_b, fav_a, fav_b, rdy_a, rdy_b} === 12'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL drop_idle busy=%b/%b rdy=%b/%b expected idle with no accept", busy_a, busy_b, rdy_a, rdy_b);
    end
    sched_en = 1'b1;
    drive_frame(0, 1'b0, o);
    checks++;
    if (obs_vec(o) !== exp_vec(2, 2, o.snap_d, o.snap_c) || o.wait_cyc !== 8'd1) begin
      fails++;
      $display("FAIL drop_resume got=%h wait=%0d expected=%h wait=1", obs_vec(o), o.wait_cyc,
               exp_vec(2, 2, o.snap_d, o.snap_c));
    end
  endtask

  task automatic test_reset_in_offer();
    frame_t o;
    int n;
    sched_en = 1'b1;
    ch_valid = 4'hF;
    ch_data = CD_W'($urandom);
    ch_cfg = CC_W'($urandom);
    apply_reset();
    #1;
    n = 0;
    while ((rdy_a | rdy_b) == 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (fav_a !== 1'b1 || fav_b !== 1'b1) begin
      fails++;
      $display("FAIL offer_before_reset av=%b/%b expected 1/1", fav_a, fav_b);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fav_a, rdy_a, busy_a, gid_a, dtx_a, fav_b, rdy_b, busy_b, gid_b, dtx_b} !==
        {1'b0, 4'b0, 1'b0, 2'd3, 8'h00, 1'b0, 4'b0, 1'b0, 2'd3, 8'h00}) begin
      fails++;
      $display("FAIL async_reset av=%b/%b rdy=%b/%b busy=%b/%b gid=%0d/%0d data=%h/%h expected 0,0,0,3,00",
               fav_a, fav_b, rdy_a, rdy_b, busy_a, busy_b, gid_a, gid_b, dtx_a, dtx_b);
    end
    ch_valid = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    drive_frame(0, 1'b0, o);
    checks++;
    if (obs_vec(o) !== exp_vec(1, 1, o.snap_d, o.snap_c)) begin
      fails++;
      $display("FAIL first_after_reset got=%h expected=%h", obs_vec(o), exp_vec(1, 1, o.snap_d, o.snap_c));
    end
  endtask

  task automatic test_random();
    frame_t o;
    int la, ca, lb, cb, ea, eb;
    logic [3:0] v;
    sched_en = 1'b1;
    ch_valid = 4'($urandom_range(1, 15));
    ch_data = CD_W'($urandom);
    ch_cfg = CC_W'($urandom);
    apply_reset();
    la = NUM_CH - 1; ca = 0;
    lb = NUM_CH - 1; cb = 0;
    for (int f = 0; f < 40; f++) begin
      v = ch_valid;
      ea = model_pick(v, la, ca, 1);
      eb = model_pick(v, lb, cb, 3);
      drive_frame($urandom_range(0, 2), 1'b0, o);
      checks++;
      if (obs_vec(o) !== exp_vec(ea, eb, o.snap_d, o.snap_c)) begin
        fails++;
        $display("FAIL random frame %0d valid=%b got=%h expected=%h", f, v, obs_vec(o),
                 exp_vec(ea, eb, o.snap_d, o.snap_c));
      end
      ca = model_keep(v, la, ca, 1) ? ca + 1 : 1;
      cb = model_keep(v, lb, cb, 3) ? cb + 1 : 1;
      la = ea;
      lb = eb;
      ch_data = CD_W'($urandom);
      ch_cfg = CC_W'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        ch_valid = 4'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, busy_b, fav_a, fav_b, rdy_a, rdy_b} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'b0}) begin
          fails++;
          $display("FAIL random_gap %0d busy=%b/%b av=%b/%b rdy=%b/%b expected waiting in arbitration",
                   f, busy_a, busy_b, fav_a, fav_b, rdy_a, rdy_b);
        end
      end
      ch_valid = 4'($urandom_range(1, 15));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_cfg_isolation();
    test_sched_en_drop();
    test_reset_in_offer();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
